// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/load/shift/rotate plus WIDTH-shift bursts under a 2-state FSM.
// Define UNIV_SHIFT_REG_ROTATE_EN to enable ROTL/ROTR; otherwise modes 4/5 behave as HOLD.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             D,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] par_i,
  output logic [WIDTH-1:0] P,
  output logic             ser_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [2:0] MODE_HOLD    = 3'd0;
  localparam logic [2:0] MODE_LOAD    = 3'd1;
  localparam logic [2:0] MODE_SHL     = 3'd2;
  localparam logic [2:0] MODE_SHR     = 3'd3;
  localparam logic [2:0] MODE_ROTL    = 3'd4;
  localparam logic [2:0] MODE_ROTR    = 3'd5;
  localparam logic [2:0] MODE_BURST_L = 3'd6;
  localparam logic [2:0] MODE_BURST_R = 3'd7;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {S_IDLE, S_BURST} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_left_q, dir_left_d;
  logic             bdir_left_q, bdir_left_d;
  logic             done_q, done_d;
  logic             burst_req;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  function automatic logic [WIDTH-1:0] shl(input logic [WIDTH-1:0] v, input logic b);
    return {v[WIDTH-2:0], b};
  endfunction

  function automatic logic [WIDTH-1:0] shr(input logic [WIDTH-1:0] v, input logic b);
    return {b, v[WIDTH-1:1]};
  endfunction

  assign burst_req = (mode_i == MODE_BURST_L) || (mode_i == MODE_BURST_R);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // A burst request seen on the final shift keeps the FSM in BURST, so the
  // next edge starts the new burst with no idle gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (burst_req) state_d = S_BURST;
      S_BURST: if ((cnt_q == CNT_LAST) && !burst_req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      p_q         <= '0;
      cnt_q       <= '0;
      dir_left_q  <= 1'b1;
      bdir_left_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      p_q         <= p_d;
      cnt_q       <= cnt_d;
      dir_left_q  <= dir_left_d;
      bdir_left_q <= bdir_left_d;
      done_q      <= done_d;
    end
  end

  // In BURST cnt_q counts shifts already made; cnt_q == WIDTH there marks a
  // pending back-to-back restart, whose edge is shift 1 of the new burst.
  always_comb begin
    p_d         = p_q;
    cnt_d       = cnt_q;
    dir_left_d  = dir_left_q;
    bdir_left_d = bdir_left_q;
    done_d      = 1'b0;
    if (state_q == S_BURST) begin
      p_d        = bdir_left_q ? shl(p_q, D) : shr(p_q, D);
      dir_left_d = bdir_left_q;
      cnt_d      = (cnt_q == CNT_MAX) ? CNT_ONE : cnt_q + CNT_ONE;
      if (cnt_q == CNT_LAST) begin
        done_d = 1'b1;
        if (burst_req) bdir_left_d = (mode_i == MODE_BURST_L);
      end
    end else begin
      case (mode_i)
        MODE_LOAD: begin
          p_d   = par_i;
          cnt_d = '0;
        end
        MODE_SHL: begin
          p_d        = shl(p_q, D);
          cnt_d      = sat_inc(cnt_q);
          dir_left_d = 1'b1;
        end
        MODE_SHR: begin
          p_d        = shr(p_q, D);
          cnt_d      = sat_inc(cnt_q);
          dir_left_d = 1'b0;
        end
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        MODE_ROTL: begin
          p_d        = shl(p_q, p_q[WIDTH-1]);
          cnt_d      = sat_inc(cnt_q);
          dir_left_d = 1'b1;
        end
        MODE_ROTR: begin
          p_d        = shr(p_q, p_q[0]);
          cnt_d      = sat_inc(cnt_q);
          dir_left_d = 1'b0;
        end
        MODE_HOLD: ;
`else
        MODE_HOLD, MODE_ROTL, MODE_ROTR: ;
`endif
        MODE_BURST_L: begin
          p_d         = shl(p_q, D);
          cnt_d       = CNT_ONE;
          dir_left_d  = 1'b1;
          bdir_left_d = 1'b1;
        end
        MODE_BURST_R: begin
          p_d         = shr(p_q, D);
          cnt_d       = CNT_ONE;
          dir_left_d  = 1'b0;
          bdir_left_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    P      = p_q;
    cnt_o  = cnt_q;
    busy_o = (state_q == S_BURST);
    done_o = done_q;
    ser_o  = dir_left_q ? p_q[WIDTH-1] : p_q[0];
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: WIDTH=8 main instance, WIDTH=16 back-to-back bursts, WIDTH=2 burst.
module tb_univ_shift_reg;

  logic        clk;
  logic        nrst;
  logic        d8, d16, d2;
  logic [2:0]  mode8, mode16, mode2;
  logic [7:0]  par8;
  logic [15:0] par16;
  logic [1:0]  par2;
  logic [7:0]  p8;
  logic [15:0] p16;
  logic [1:0]  p2;
  logic        ser8, ser16, ser2;
  logic [3:0]  cnt8;
  logic [4:0]  cnt16;
  logic [1:0]  cnt2;
  logic        busy8, busy16, busy2;
  logic        done8, done16, done2;

  int n_vec = 0;
  int n_err = 0;

  univ_shift_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .nrst(nrst), .D(d8), .mode_i(mode8), .par_i(par8),
    .P(p8), .ser_o(ser8), .cnt_o(cnt8), .busy_o(busy8), .done_o(done8)
  );

  univ_shift_reg #(.WIDTH(16)) dut16 (
    .clk(clk), .nrst(nrst), .D(d16), .mode_i(mode16), .par_i(par16),
    .P(p16), .ser_o(ser16), .cnt_o(cnt16), .busy_o(busy16), .done_o(done16)
  );

  univ_shift_reg #(.WIDTH(2)) dut2 (
    .clk(clk), .nrst(nrst), .D(d2), .mode_i(mode2), .par_i(par2),
    .P(p2), .ser_o(ser2), .cnt_o(cnt2), .busy_o(busy2), .done_o(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] stream10;
    int busy_n, done_n, done_at, last_done, gap_bad;

    nrst   = 1'b1;
    d8     = 1'b0; d16 = 1'b0; d2 = 1'b0;
    mode8  = 3'd1; mode16 = 3'd0; mode2 = 3'd0;
    par8   = 8'h77; par16 = 16'h0000; par2 = 2'b00;
    #2 nrst = 1'b0;
    #1;
    chk("async_rst_P", p8, 8'h00);
    chk("async_rst_cnt", cnt8, 0);
    chk("async_rst_busy", busy8, 0);
    chk("async_rst_done", done8, 0);
    chk("async_rst_ser", ser8, 0);

    // LOAD held during reset must be ignored
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_load_ignored_P", p8, 8'h00);
      chk("rst_load_ignored_cnt", cnt8, 0);
    end
    @(negedge clk);
    nrst  = 1'b1;
    mode8 = 3'd0;
    #1;
    chk("release_P", p8, 8'h00);
    chk("release_cnt", cnt8, 0);
    tick();
    chk("hold_after_release_P", p8, 8'h00);

    // SHL 1,0,1,0,1,0,1,0
    mode8 = 3'd2;
    for (int i = 0; i < 8; i++) begin
      d8 = (i % 2 == 0);
      tick();
    end
    chk("shl_P", p8, 8'hAA);
    chk("shl_cnt", cnt8, 8);
    chk("shl_ser", ser8, 1);

    mode8 = 3'd1; par8 = 8'h00; tick();
    chk("load0_P", p8, 8'h00);
    chk("load0_cnt", cnt8, 0);

    mode8 = 3'd3;
    for (int i = 0; i < 8; i++) begin
      d8 = (i % 2 == 0);
      tick();
    end
    chk("shr_P", p8, 8'h55);
    chk("shr_cnt", cnt8, 8);
    chk("shr_ser", ser8, 1);

    // 10-bit stream saturates the counter
    mode8 = 3'd1; par8 = 8'h00; tick();
    stream10 = 8'b10101011;
    mode8 = 3'd2;
    d8 = 1'b1; tick();
    d8 = 1'b0; tick();
    for (int i = 7; i >= 0; i--) begin
      d8 = stream10[i];
      tick();
    end
    chk("shl10_P", p8, 8'hAB);
    chk("shl10_cnt_sat", cnt8, 8);

    mode8 = 3'd0; d8 = 1'b0; tick();
    chk("hold_P", p8, 8'hAB);
    chk("hold_cnt", cnt8, 8);

    mode8 = 3'd1; par8 = 8'h81; tick();
    chk("load81_P", p8, 8'h81);
    mode8 = 3'd4; tick();
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    chk("rotl_P", p8, 8'h03);
    chk("rotl_cnt", cnt8, 1);
`else
    chk("rotl_as_hold_P", p8, 8'h81);
    chk("rotl_as_hold_cnt", cnt8, 0);
`endif
    mode8 = 3'd5; tick();
    chk("rotr_P", p8, 8'h81);

    // Left burst, D=1; LOAD presented mid-burst must be ignored
    mode8 = 3'd1; par8 = 8'h00; tick();
    mode8 = 3'd6; d8 = 1'b1; tick();
    chk("burst_first_P", p8, 8'h01);
    chk("burst_first_cnt", cnt8, 1);
    busy_n = 0; done_n = 0; done_at = -1;
    for (int i = 0; i < 12; i++) begin
      if (busy8) busy_n++;
      if (done8) begin done_n++; done_at = i; end
      mode8 = (i < 5) ? 3'd1 : 3'd0;
      tick();
    end
    chk("burst_busy_cycles", busy_n, 7);
    chk("burst_done_pulses", done_n, 1);
    chk("burst_done_time", done_at, 7);
    chk("burst_P", p8, 8'hFF);
    chk("burst_cnt", cnt8, 8);
    chk("burst_ser", ser8, 1);

    // Reset during shift 4 aborts the burst
    mode8 = 3'd1; par8 = 8'h00; tick();
    mode8 = 3'd6; d8 = 1'b1; tick();
    mode8 = 3'd0;
    tick(); tick(); tick();
    chk("abort_pre_P", p8, 8'h0F);
    chk("abort_pre_cnt", cnt8, 4);
    nrst = 1'b0;
    #1;
    chk("abort_P", p8, 8'h00);
    chk("abort_busy", busy8, 0);
    chk("abort_cnt", cnt8, 0);
    chk("abort_done", done8, 0);
    @(negedge clk);
    nrst = 1'b1;
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy8) busy_n++;
      if (done8) done_n++;
    end
    chk("abort_no_busy", busy_n, 0);
    chk("abort_no_done", done_n, 0);
    chk("abort_idle_P", p8, 8'h00);

    // WIDTH=16, BURST_R held: done every 16 cycles, busy never drops
    mode16 = 3'd7; d16 = 1'b1; tick();
    busy_n = 0; done_n = 0; last_done = -1; gap_bad = 0; done_at = -1;
    for (int i = 0; i < 64; i++) begin
      if (busy16) busy_n++;
      if (done16) begin
        done_n++;
        if (last_done < 0) done_at = i;
        else if (i - last_done != 16) gap_bad++;
        last_done = i;
      end
      tick();
    end
    chk("b2b_busy_all", busy_n, 64);
    chk("b2b_done_pulses", done_n, 4);
    chk("b2b_first_done", done_at, 15);
    chk("b2b_gap_errors", gap_bad, 0);
    chk("b2b_P", p16, 16'hFFFF);
    chk("b2b_ser_right", ser16, 1);
    mode16 = 3'd0;
    for (int i = 0; i < 20; i++) tick();
    chk("b2b_end_busy", busy16, 0);
    chk("b2b_end_cnt", cnt16, 16);

    // WIDTH=2 burst
    mode2 = 3'd6; d2 = 1'b1; tick();
    mode2 = 3'd0;
    chk("w2_first_P", p2, 2'b01);
    chk("w2_busy", busy2, 1);
    chk("w2_done_early", done2, 0);
    tick();
    chk("w2_P", p2, 2'b11);
    chk("w2_done", done2, 1);
    chk("w2_busy_end", busy2, 0);
    chk("w2_cnt", cnt2, 2);
    tick();
    chk("w2_done_single", done2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
